// File: rtl/mac_pkg.sv
// Shared MAC-array definitions: weight precision type and helpers used by
// the bit-serial weight FIFO.
package mac_pkg;

    localparam int MAX_PREC = 8;
    localparam int PREC_W   = 4;

    typedef logic [PREC_W-1:0] prec_t;

    // Map 0 and anything above max_p onto max_p so word tracking never sees a zero length.
    function automatic prec_t sanitize_prec(input prec_t p, input prec_t max_p);
        prec_t r;
        if ((p == 4'd0) || (p > max_p)) begin
            r = max_p;
        end else begin
            r = p;
        end
        return r;
    endfunction

    function automatic prec_t next_bit(input prec_t b, input prec_t p);
        prec_t r;
        if (b >= (p - 4'd1)) begin
            r = 4'd0;
        end else begin
            r = b + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bitserial_fifo_mc_if.sv
// Handshake, data and status bundle of the bit-serial weight FIFO.
interface bitserial_fifo_mc_if #(
    parameter int LANES = 4,
    parameter int DEPTH = 64
);
    logic                    clear;
    mac_pkg::prec_t          precision;
    logic                    wr_en;
    logic [LANES-1:0]        din;
    logic                    rd_en;
    logic [LANES-1:0]        dout;
    logic                    dout_valid;
    logic                    dout_last;
    logic                    word_ready;
    logic [$clog2(DEPTH):0]  count;
    logic                    full;
    logic                    almost_full;
    logic                    empty;
    logic                    overflow;
    logic                    underflow;

    modport slave (
        input  clear, precision, wr_en, din, rd_en,
        output dout, dout_valid, dout_last, word_ready, count,
               full, almost_full, empty, overflow, underflow
    );

    modport master (
        output clear, precision, wr_en, din, rd_en,
        input  dout, dout_valid, dout_last, word_ready, count,
               full, almost_full, empty, overflow, underflow
    );
endinterface

// File: rtl/lane_mem.sv
// DEPTH x LANES simple dual-port storage; the read port is registered and
// holds its value when no read is issued.
module lane_mem #(
    parameter int LANES = 4,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [LANES-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [LANES-1:0] rdata
);

    logic [LANES-1:0] mem_q [DEPTH];
    logic [LANES-1:0] rdata_q;
    logic [LANES-1:0] rdata_d;

    // Storage array write port; a same-address read sees the old entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Next read-data selection.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read-data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= {LANES{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bitserial_fifo_mc.sv
// Multi-lane bit-serial weight FIFO with shared pointers, word-boundary
// tracking for a runtime precision, and sticky error flags.
module bitserial_fifo_mc #(
    parameter int LANES        = 4,
    parameter int DEPTH        = 64,
    parameter int MAX_PREC     = mac_pkg::MAX_PREC,
    parameter int AFULL_MARGIN = 8
) (
    input  logic                clk,
    input  logic                rst,
    bitserial_fifo_mc_if.slave  bus
);
    import mac_pkg::*;

    localparam int    AW    = $clog2(DEPTH);
    localparam int    CW    = AW + 1;
    localparam int    RW    = (CW > PREC_W) ? CW : PREC_W;
    localparam prec_t MAX_P = prec_t'(MAX_PREC);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    prec_t         wr_bit_q, wr_bit_d, rd_bit_q, rd_bit_d, prec_q, prec_d;
    logic          overflow_q, overflow_d, underflow_q, underflow_d;
    logic          dout_valid_q, dout_valid_d, dout_last_q, dout_last_d;

    logic          full_s, empty_s, almost_full_s, idle_s;
    logic          rd_acc_s, wr_acc_s, mem_we_s, mem_re_s, word_ready_s;
    prec_t         prec_in_s, prec_wr_s;
    logic [RW-1:0] rem_s;
    logic [LANES-1:0] mem_rdata_s;

    // Status decode and accept logic, all from registered state.
    always_comb begin
        full_s        = (count_q == CW'(DEPTH));
        empty_s       = (count_q == {CW{1'b0}});
        almost_full_s = (count_q >= CW'(DEPTH - AFULL_MARGIN));
        idle_s        = empty_s && (wr_bit_q == 4'd0) && (rd_bit_q == 4'd0);
        prec_in_s     = sanitize_prec(bus.precision, MAX_P);
        // A write on the idle cycle starts a word at the precision being latched.
        prec_wr_s     = idle_s ? prec_in_s : prec_q;
        rd_acc_s      = bus.rd_en && !empty_s;
        wr_acc_s      = bus.wr_en && (!full_s || rd_acc_s);
        mem_we_s      = wr_acc_s && !bus.clear;
        mem_re_s      = rd_acc_s && !bus.clear;
        rem_s         = RW'(prec_q) - RW'(rd_bit_q);
        word_ready_s  = (RW'(count_q) >= rem_s);
    end

    // Next-state computation; clear overrides any concurrent read or write.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        wr_bit_d     = wr_bit_q;
        rd_bit_d     = rd_bit_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;
        prec_d       = prec_wr_s;

        if (bus.clear) begin
            wr_ptr_d    = {AW{1'b0}};
            rd_ptr_d    = {AW{1'b0}};
            count_d     = {CW{1'b0}};
            wr_bit_d    = 4'd0;
            rd_bit_d    = 4'd0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1'b1);
                wr_bit_d = next_bit(wr_bit_q, prec_wr_s);
            end else begin
                wr_ptr_d = wr_ptr_q;
                wr_bit_d = wr_bit_q;
            end

            if (rd_acc_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
                rd_bit_d = next_bit(rd_bit_q, prec_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
                rd_bit_d = rd_bit_q;
            end

            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_d = count_q + CW'(1'b1);
                2'b01:   count_d = count_q - CW'(1'b1);
                default: count_d = count_q;
            endcase

            overflow_d   = overflow_q  || (bus.wr_en && !wr_acc_s);
            underflow_d  = underflow_q || (bus.rd_en && empty_s);
            dout_valid_d = rd_acc_s;
            dout_last_d  = rd_acc_s && (rd_bit_q == (prec_q - 4'd1));
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= {CW{1'b0}};
            wr_bit_q     <= 4'd0;
            rd_bit_q     <= 4'd0;
            prec_q       <= MAX_P;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wr_bit_q     <= wr_bit_d;
            rd_bit_q     <= rd_bit_d;
            prec_q       <= prec_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
        end
    end

    lane_mem #(
        .LANES (LANES),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we_s),
        .waddr (wr_ptr_q),
        .wdata (bus.din),
        .re    (mem_re_s),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata_s)
    );

    assign bus.dout        = mem_rdata_s;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.dout_last   = dout_last_q;
    assign bus.word_ready  = word_ready_s;
    assign bus.count       = count_q;
    assign bus.full        = full_s;
    assign bus.almost_full = almost_full_s;
    assign bus.empty       = empty_s;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_bitserial_fifo_mc.sv
// Directed self-checking bench for bitserial_fifo_mc (LANES=4, DEPTH=64).
module tb_bitserial_fifo_mc;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bitserial_fifo_mc_if #(.LANES(4), .DEPTH(64)) bus ();

    bitserial_fifo_mc #(
        .LANES(4), .DEPTH(64), .MAX_PREC(8), .AFULL_MARGIN(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d);
        bus.wr_en = 1'b1;
        bus.din   = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    task automatic chk_reset(input string p);
        chk({p, ".dout"},        32'(bus.dout),        32'h0);
        chk({p, ".dout_valid"},  32'(bus.dout_valid),  32'h0);
        chk({p, ".dout_last"},   32'(bus.dout_last),   32'h0);
        chk({p, ".word_ready"},  32'(bus.word_ready),  32'h0);
        chk({p, ".count"},       32'(bus.count),       32'h0);
        chk({p, ".full"},        32'(bus.full),        32'h0);
        chk({p, ".almost_full"}, 32'(bus.almost_full), 32'h0);
        chk({p, ".empty"},       32'(bus.empty),       32'h1);
        chk({p, ".overflow"},    32'(bus.overflow),    32'h0);
        chk({p, ".underflow"},   32'(bus.underflow),   32'h0);
    endtask

    initial begin
        logic [3:0] exp_d;
        rst           = 1'b1;
        bus.clear     = 1'b0;
        bus.precision = 4'd4;
        bus.wr_en     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.din       = 4'h0;
        step();
        step();
        chk_reset("reset");
        rst = 1'b0;
        step();

        // Fill and drain 32 entries at precision 4.
        for (int i = 0; i < 32; i++) begin
            push((i % 2 == 0) ? 4'b0101 : 4'b1010);
        end
        chk("fill32.count",       32'(bus.count),       32'd32);
        chk("fill32.word_ready",  32'(bus.word_ready),  32'h1);
        chk("fill32.almost_full", 32'(bus.almost_full), 32'h0);
        for (int i = 0; i < 32; i++) begin
            pop();
            chk("drain32.dout",  32'(bus.dout),       (i % 2 == 0) ? 32'h5 : 32'hA);
            chk("drain32.valid", 32'(bus.dout_valid), 32'h1);
            chk("drain32.last",  32'(bus.dout_last),  (i % 4 == 3) ? 32'h1 : 32'h0);
        end
        chk("drain32.empty", 32'(bus.empty), 32'h1);
        chk("drain32.count", 32'(bus.count), 32'd0);
        step();
        chk("idle.valid", 32'(bus.dout_valid), 32'h0);

        // Read while empty.
        pop();
        chk("uflow.flag",  32'(bus.underflow),  32'h1);
        chk("uflow.valid", 32'(bus.dout_valid), 32'h0);
        chk("uflow.count", 32'(bus.count),      32'd0);

        // Fill to DEPTH, then overflow and write-through-full.
        for (int i = 0; i < 64; i++) begin
            push(4'(i));
            if (i == 54) chk("fill64.afull55", 32'(bus.almost_full), 32'h0);
            if (i == 55) chk("fill64.afull56", 32'(bus.almost_full), 32'h1);
            if (i == 62) chk("fill64.full63",  32'(bus.full),        32'h0);
        end
        chk("fill64.full",  32'(bus.full),  32'h1);
        chk("fill64.count", 32'(bus.count), 32'd64);
        push(4'h5);
        chk("oflow.flag",  32'(bus.overflow), 32'h1);
        chk("oflow.count", 32'(bus.count),    32'd64);
        bus.wr_en = 1'b1;
        bus.din   = 4'hA;
        bus.rd_en = 1'b1;
        step();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        chk("wrfull.count", 32'(bus.count),      32'd64);
        chk("wrfull.dout",  32'(bus.dout),       32'h0);
        chk("wrfull.valid", 32'(bus.dout_valid), 32'h1);
        for (int k = 1; k <= 64; k++) begin
            pop();
            exp_d = (k < 64) ? 4'(k) : 4'hA;
            chk("drain64.dout", 32'(bus.dout), 32'(exp_d));
        end
        chk("drain64.empty",   32'(bus.empty),     32'h1);
        chk("sticky.overflow", 32'(bus.overflow),  32'h1);
        chk("sticky.uflow",    32'(bus.underflow), 32'h1);
        do_clear();
        chk("clr.overflow", 32'(bus.overflow),  32'h0);
        chk("clr.uflow",    32'(bus.underflow), 32'h0);

        // word_ready at precision 3.
        bus.precision = 4'd3;
        step();
        push(4'h1);
        push(4'h2);
        chk("wr3.after2", 32'(bus.word_ready), 32'h0);
        push(4'h3);
        chk("wr3.after3", 32'(bus.word_ready), 32'h1);
        pop();
        chk("wr3.rd.dout", 32'(bus.dout),       32'h1);
        chk("wr3.rd.last", 32'(bus.dout_last),  32'h0);
        chk("wr3.rd.wr",   32'(bus.word_ready), 32'h1);
        push(4'h4);
        push(4'h5);
        chk("wr3.final.wr",    32'(bus.word_ready), 32'h1);
        chk("wr3.final.count", 32'(bus.count),      32'd4);
        do_clear();

        // Precision change ignored while words are in flight.
        bus.precision = 4'd4;
        step();
        for (int i = 1; i <= 5; i++) push(4'(i));
        bus.precision = 4'd8;
        step();
        step();
        for (int i = 6; i <= 8; i++) push(4'(i));
        for (int i = 0; i < 8; i++) begin
            pop();
            chk("prec4.dout", 32'(bus.dout),      32'(i + 1));
            chk("prec4.last", 32'(bus.dout_last), (i == 3 || i == 7) ? 32'h1 : 32'h0);
        end
        bus.precision = 4'd0;
        step();
        for (int i = 0; i < 16; i++) push(4'(i));
        for (int i = 0; i < 16; i++) begin
            pop();
            chk("prec8.dout", 32'(bus.dout),      32'(i));
            chk("prec8.last", 32'(bus.dout_last), (i % 8 == 7) ? 32'h1 : 32'h0);
        end

        // clear beats concurrent write and read.
        for (int i = 0; i < 10; i++) push(4'h3);
        chk("preclr.count", 32'(bus.count), 32'd10);
        bus.clear = 1'b1;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.din   = 4'hC;
        step();
        bus.clear = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        chk("clr.count",    32'(bus.count),      32'd0);
        chk("clr.empty",    32'(bus.empty),      32'h1);
        chk("clr.overflow", 32'(bus.overflow),   32'h0);
        chk("clr.valid",    32'(bus.dout_valid), 32'h0);
        chk("clr.dout",     32'(bus.dout),       32'hF);
        pop();
        chk("clr.nowrite.uflow", 32'(bus.underflow), 32'h1);
        chk("clr.nowrite.count", 32'(bus.count),     32'd0);

        // Asynchronous reset mid-stream.
        push(4'h6);
        push(4'h7);
        push(4'h8);
        pop();
        chk("pre_rst.dout",  32'(bus.dout),       32'h6);
        chk("pre_rst.valid", 32'(bus.dout_valid), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
